// File: rtl/ibuffer_vc_if.sv
// Link-side and routing-side signal bundle of the multi-VC input buffer.
// Latency: none, wiring only.
// Backpressure: carries the per-VC Stop & Go lines back to the upstream sender.
interface ibuffer_vc_if #(
    parameter int FLIT_SIZE      = 64,
    parameter int PHIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int NUM_VC         = 2,
    parameter int QUEUE_SIZE     = 8
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int QW  = $clog2(QUEUE_SIZE);

    // link side
    logic [PHIT_SIZE-1:0]              Flit;
    logic [FLIT_TYPE_SIZE-1:0]         FlitType;
    logic                              BroadcastFlit;
    logic [VCW-1:0]                    VC;
    logic                              Valid;
    logic [NUM_VC-1:0]                 Go;

    // routing side
    logic [NUM_VC-1:0]                 Req_RT;
    logic [NUM_VC-1:0]                 Avail;
    logic [NUM_VC*FLIT_SIZE-1:0]       FlitOut;
    logic [NUM_VC*FLIT_TYPE_SIZE-1:0]  FlitTypeOut;
    logic [NUM_VC-1:0]                 BroadcastFlitOut;

    // status
    logic [NUM_VC*(QW+1)-1:0]          Occupancy;
    logic [NUM_VC-1:0]                 Overflow;

    // environment: drives phits and routing availability
    modport master (
        output Flit, FlitType, BroadcastFlit, VC, Valid, Avail,
        input  Go, Req_RT, FlitOut, FlitTypeOut, BroadcastFlitOut, Occupancy, Overflow
    );

    // buffer itself
    modport slave (
        input  Flit, FlitType, BroadcastFlit, VC, Valid, Avail,
        output Go, Req_RT, FlitOut, FlitTypeOut, BroadcastFlitOut, Occupancy, Overflow
    );
endinterface

// File: rtl/ibuffer_vc.sv
// Multi-VC input buffer: reassembles phits into flits and queues them per VC.
// Latency: last phit at edge N -> Occupancy at N, Req_RT earliest in cycle N+1.
// Backpressure: registered per-VC Stop & Go with hysteresis; flits to a full VC are dropped.
module ibuffer_vc #(
    parameter int FLIT_SIZE      = 64,
    parameter int PHIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int NUM_VC         = 2,
    parameter int QUEUE_SIZE     = 8,
    parameter int SG_UPPER_THOLD = 6,
    parameter int SG_LOWER_THOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ibuffer_vc_if.slave  bus
);
    localparam int NUM_PHITS = FLIT_SIZE / PHIT_SIZE;
    localparam int PCW       = (NUM_PHITS > 1) ? $clog2(NUM_PHITS) : 1;
    localparam int QW        = $clog2(QUEUE_SIZE);
    localparam logic [PCW-1:0] LAST_PHIT = PCW'(NUM_PHITS - 1);
    localparam logic [QW:0]    CNT_FULL  = (QW+1)'(QUEUE_SIZE);

    logic [PCW-1:0]       phit_cnt;
    logic [FLIT_SIZE-1:0] asm_q;
    logic [FLIT_SIZE-1:0] flit_full;
    logic                 last_phit;

    // A flit completes on the valid phit that lands in the top slice.
    always_comb begin
        last_phit = bus.Valid && (phit_cnt == LAST_PHIT);
        flit_full = asm_q;
        flit_full[FLIT_SIZE-PHIT_SIZE +: PHIT_SIZE] = bus.Flit;
    end

    // Phit counter and assembly register; reset discards any partial flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phit_cnt <= '0;
            asm_q    <= '0;
        end else if (bus.Valid) begin
            asm_q[int'(phit_cnt)*PHIT_SIZE +: PHIT_SIZE] <= bus.Flit;
            phit_cnt <= last_phit ? '0 : phit_cnt + 1'b1;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [FLIT_SIZE-1:0]      dat_mem [QUEUE_SIZE];
        logic [FLIT_TYPE_SIZE-1:0] typ_mem [QUEUE_SIZE];
        logic                      bc_mem  [QUEUE_SIZE];
        logic [QW-1:0]             wr_ptr;
        logic [QW-1:0]             rd_ptr;
        logic [QW:0]               cnt;
        logic                      go_q;
        logic                      ovf_q;
        logic                      push_sel;
        logic                      pop;
        logic                      full;
        logic                      accept;
        logic                      drop;

        // Per-VC push/pop decisions; a VC id with no matching queue selects nothing.
        always_comb begin
            push_sel = last_phit && (int'(bus.VC) == v);
            pop      = bus.Avail[v] && (cnt != '0);
            full     = (cnt == CNT_FULL);
            accept   = push_sel && (!full || pop);
            drop     = push_sel && full && !pop;
        end

        // Pointers, occupancy, sticky overflow and Stop & Go hysteresis.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                go_q   <= 1'b1;
                ovf_q  <= 1'b0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (pop)    rd_ptr <= rd_ptr + 1'b1;
                case ({accept, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (drop) ovf_q <= 1'b1;
                go_q <= go_q ? (int'(cnt) < SG_UPPER_THOLD)
                             : (int'(cnt) < SG_LOWER_THOLD);
            end
        end

        // Queue storage is datapath only and is left unreset.
        always_ff @(posedge clk) begin
            if (accept) begin
                dat_mem[wr_ptr] <= flit_full;
                typ_mem[wr_ptr] <= bus.FlitType;
                bc_mem[wr_ptr]  <= bus.BroadcastFlit;
            end
        end

        assign bus.Req_RT[v]                                   = pop;
        assign bus.Go[v]                                       = go_q;
        assign bus.Overflow[v]                                 = ovf_q;
        assign bus.Occupancy[v*(QW+1) +: QW+1]                 = cnt;
        assign bus.FlitOut[v*FLIT_SIZE +: FLIT_SIZE]           = dat_mem[rd_ptr];
        assign bus.FlitTypeOut[v*FLIT_TYPE_SIZE +: FLIT_TYPE_SIZE] = typ_mem[rd_ptr];
        assign bus.BroadcastFlitOut[v]                         = bc_mem[rd_ptr];
    end
endmodule

// File: tb/tb_ibuffer_vc.sv
// Randomized scoreboard bench for ibuffer_vc: 64-bit flits over 16-bit phits, 2 VCs.
// Latency: expected flits become poppable on the edge that samples their last phit.
// Backpressure: Go and Overflow are predicted from queue sizes with the threshold rules.
module tb_ibuffer_vc;
    localparam int FS = 64;
    localparam int PS = 16;
    localparam int NV = 2;
    localparam int QS = 8;
    localparam int UP = 6;
    localparam int LO = 4;

    typedef struct packed {
        logic [63:0] dat;
        logic [1:0]  typ;
        logic        bc;
    } ent_t;

    logic clk;
    logic rst_n;

    ibuffer_vc_if #(.FLIT_SIZE(FS), .PHIT_SIZE(PS), .FLIT_TYPE_SIZE(2),
                    .NUM_VC(NV), .QUEUE_SIZE(QS)) bus ();

    ibuffer_vc #(.FLIT_SIZE(FS), .PHIT_SIZE(PS), .FLIT_TYPE_SIZE(2), .NUM_VC(NV),
                 .QUEUE_SIZE(QS), .SG_UPPER_THOLD(UP), .SG_LOWER_THOLD(LO))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // reference model state
    ent_t        sb [NV][$];
    logic [1:0]  popped;
    logic [1:0]  m_go;
    logic [1:0]  m_ovf;
    ent_t        pend_e;
    int          pend_vc;
    bit          pend_vld;
    bit          chk_en;
    bit          rand_avail;

    int n_cmp;
    int n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) sb[v].delete();
        popped   = '0;
        m_go     = '1;
        m_ovf    = '0;
        pend_vld = 1'b0;
    endtask

    // Model update on each sampling edge: Go from the pre-edge size, then the push.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                for (int v = 0; v < NV; v++) begin
                    int c_before;
                    c_before = sb[v].size() + int'(popped[v]);
                    m_go[v]  = m_go[v] ? (c_before < UP) : (c_before < LO);
                end
                if (pend_vld) begin
                    if (sb[pend_vc].size() + int'(popped[pend_vc]) == QS && !popped[pend_vc])
                        m_ovf[pend_vc] = 1'b1;
                    else
                        sb[pend_vc].push_back(pend_e);
                    pend_vld = 1'b0;
                end
                popped = '0;
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on each request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                for (int v = 0; v < NV; v++) begin
                    logic exp_req;
                    ent_t e;
                    exp_req = bus.Avail[v] && (sb[v].size() != 0);
                    chk("occupancy", 64'(bus.Occupancy[v*4 +: 4]), 64'(sb[v].size()));
                    chk("go", 64'(bus.Go[v]), 64'(m_go[v]));
                    chk("overflow", 64'(bus.Overflow[v]), 64'(m_ovf[v]));
                    chk("req_rt", 64'(bus.Req_RT[v]), 64'(exp_req));
                    if (bus.Req_RT[v]) begin
                        if (sb[v].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL pop_empty: vc %0d requested with nothing expected", v);
                        end else begin
                            e = sb[v].pop_front();
                            chk("flit_out", bus.FlitOut[v*FS +: FS], e.dat);
                            chk("flit_type_out", 64'(bus.FlitTypeOut[v*2 +: 2]), 64'(e.typ));
                            chk("bcast_out", 64'(bus.BroadcastFlitOut[v]), 64'(e.bc));
                            popped[v] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_avail) bus.Avail = 2'($urandom_range(0, 3));
    endtask

    // One flit as four phits; optional idle cycle after phit gap_after.
    task automatic send(input int vc, input int gap_after, input bit avail_last);
        ent_t e;
        e.dat = {$urandom, $urandom};
        e.typ = 2'($urandom);
        e.bc  = 1'($urandom);
        for (int p = 0; p < 4; p++) begin
            bus.Valid = 1'b1;
            bus.Flit  = e.dat[p*PS +: PS];
            if (p == 3) begin
                bus.VC            = 1'(vc);
                bus.FlitType      = e.typ;
                bus.BroadcastFlit = e.bc;
                pend_e   = e;
                pend_vc  = vc;
                pend_vld = 1'b1;
                if (avail_last) bus.Avail[0] = 1'b1;
            end else begin
                bus.VC            = 1'($urandom);
                bus.FlitType      = 2'($urandom);
                bus.BroadcastFlit = 1'($urandom);
            end
            tick();
            if (p == 3 && avail_last) bus.Avail[0] = 1'b0;
            if (p == gap_after) begin
                bus.Valid = 1'b0;
                bus.Flit  = 16'($urandom);
                tick();
            end
        end
        bus.Valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        chk_en = 1'b0;
        rand_avail = 1'b0;
        model_reset();
        rst_n = 1'b0;
        bus.Flit = '0;
        bus.FlitType = '0;
        bus.BroadcastFlit = 1'b0;
        bus.VC = '0;
        bus.Valid = 1'b0;
        bus.Avail = 2'b11;

        // reset values while held in reset
        #12;
        chk("rst_req", 64'(bus.Req_RT), 64'd0);
        chk("rst_go", 64'(bus.Go), 64'h3);
        chk("rst_ovf", 64'(bus.Overflow), 64'd0);
        chk("rst_occ", 64'(bus.Occupancy), 64'd0);
        rst_n = 1'b1;
        bus.Avail = 2'b00;
        chk_en = 1'b1;
        tick();

        // three flits on VC0 held, then released in order
        send(0, -1, 1'b0);
        send(0, 1, 1'b0);
        send(0, 0, 1'b0);
        repeat (3) tick();
        bus.Avail[0] = 1'b1;
        repeat (6) tick();
        bus.Avail[0] = 1'b0;

        // multi-phit flit with a gap after phit 1 on VC1
        send(1, 1, 1'b0);
        repeat (2) tick();

        // fill VC1 past the Stop threshold, then drain to 3
        for (int i = 0; i < 7; i++) send(1, -1, 1'b0);
        repeat (3) tick();
        bus.Avail[1] = 1'b1;
        repeat (5) tick();
        bus.Avail[1] = 1'b0;
        repeat (4) tick();

        // VC0 full: push with same-cycle pop, then push that must drop
        for (int i = 0; i < 8; i++) send(0, -1, 1'b0);
        tick();
        send(0, -1, 1'b1);
        tick();
        send(0, 2, 1'b0);
        repeat (3) tick();
        bus.Avail = 2'b11;
        repeat (14) tick();

        // randomized traffic with random availability and gaps
        rand_avail = 1'b1;
        for (int i = 0; i < 30; i++)
            send(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 4) - 1, 1'b0);
        rand_avail = 1'b0;
        bus.Avail = 2'b11;
        repeat (20) tick();

        // reset mid-flit with queued data
        bus.Avail = 2'b00;
        send(0, -1, 1'b0);
        send(1, -1, 1'b0);
        send(0, -1, 1'b0);
        bus.Valid = 1'b1;
        bus.Flit = 16'hdead;
        tick();
        bus.Flit = 16'hbeef;
        tick();
        #2;
        rst_n = 1'b0;
        bus.Avail = 2'b11;
        bus.Valid = 1'b0;
        model_reset();
        #1;
        chk("midrst_req", 64'(bus.Req_RT), 64'd0);
        chk("midrst_go", 64'(bus.Go), 64'h3);
        chk("midrst_ovf", 64'(bus.Overflow), 64'd0);
        chk("midrst_occ", 64'(bus.Occupancy), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // partial flit must be gone: a fresh flit assembles from phit 0
        send(1, -1, 1'b0);
        send(0, 2, 1'b0);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
